// File: rtl/multiword_add_seq.sv
// Multi-word add sequencer: feeds one WORD_W-wide adder slice per cycle, LSW first,
// chaining carries between slices and presenting the assembled wide sum downstream.
module multiword_add_seq #(
  parameter int WORD_W = 32,
  parameter int NWORDS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WORD_W*NWORDS-1:0]   in_a,
  input  logic [WORD_W*NWORDS-1:0]   in_b,
  input  logic                       in_cin,
  output logic [WORD_W-1:0]          add_a,
  output logic [WORD_W-1:0]          add_b,
  output logic                       add_cin,
  input  logic [WORD_W-1:0]          add_sum,
  input  logic                       add_cout,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WORD_W*NWORDS-1:0]   out_sum,
  output logic                       out_cout
);

  // state   | meaning
  // S_IDLE  | waiting for operands, in_ready high
  // S_RUN   | issuing slice idx_q to the adder, capturing its sum/carry
  // S_DONE  | wide result held on out_*, waiting for out_ready
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam int IDXW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

  state_t                     state_q;
  logic [IDXW-1:0]            idx_q;
  logic                       carry_q;
  logic [WORD_W*NWORDS-1:0]   a_q;
  logic [WORD_W*NWORDS-1:0]   b_q;
  logic [WORD_W*NWORDS-1:0]   sum_q;
  logic                       cout_q;
  logic                       out_valid_q;
  logic                       accept;

  // DONE forwards out_ready so a new operand can be taken in the same cycle the result leaves.
  always_comb begin
    in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    accept   = in_valid && in_ready;
    add_a    = '0;
    add_b    = '0;
    add_cin  = 1'b0;
    if (state_q == S_RUN) begin
      add_a   = a_q[idx_q*WORD_W +: WORD_W];
      add_b   = b_q[idx_q*WORD_W +: WORD_W];
      add_cin = carry_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_RUN: begin
          sum_q[idx_q*WORD_W +: WORD_W] <= add_sum;
          carry_q <= add_cout;
          if (idx_q == LAST_IDX) begin
            idx_q       <= '0;
            cout_q      <= add_cout;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      // Accept overrides the IDLE fallthrough above when a new operand arrives in DONE.
      if (accept) begin
        a_q     <= in_a;
        b_q     <= in_b;
        carry_q <= in_cin;
        idx_q   <= '0;
        state_q <= S_RUN;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;

endmodule
